// File: rtl/adder_stage1_pipe_pkg.sv
// Shared constants and helpers for the prefix-adder operand-capture stage.
package adder_stage1_pipe_pkg;

  localparam int LEN_DATA  = 32;
  localparam int DEF_TAG_W = 4;

  // Subtraction is A + ~B + 1, so the subtract flag toggles the incoming carry.
  function automatic logic fold_carry(input logic cin, input logic sub);
    return cin ^ sub;
  endfunction

endpackage

// File: rtl/adder_stage1_pipe_if.sv
// Upstream operand handshake and downstream g/p/h result bus of stage 1.
interface adder_stage1_pipe_if
  import adder_stage1_pipe_pkg::*;
#(
  parameter int DATA_W = LEN_DATA,
  parameter int TAG_W  = DEF_TAG_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              in_sub;
  logic              in_cin;
  logic [TAG_W-1:0]  in_tag;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] generate_out;
  logic [DATA_W-1:0] propogate_out;
  logic [DATA_W-1:0] halfsum_out;
  logic              cin_out;
  logic [TAG_W-1:0]  tag_out;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, generate_out, propogate_out, halfsum_out,
           cin_out, tag_out
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, in_tag, out_ready,
    output in_ready, out_valid, generate_out, propogate_out, halfsum_out,
           cin_out, tag_out
  );

endinterface

// File: rtl/adder_stage1_pipe_gp_bit_cell.sv
// One bit of generate/propagate/half-sum; bit 0 folds the carry-in into g.
module adder_stage1_pipe_gp_bit_cell #(
  parameter bit CARRY_FOLD = 1'b0
) (
  input  logic a,
  input  logic b,
  input  logic sub,
  input  logic cin,
  output logic g,
  output logic p,
  output logic h
);

  logic b_eff;

  assign b_eff = b ^ sub;
  assign h     = a ^ b_eff;
  assign p     = h;
  assign g     = (a & b_eff) | (CARRY_FOLD ? (h & cin) : 1'b0);

endmodule

// File: rtl/adder_stage1_pipe.sv
// Stage 1 of the prefix adder: forms g/p/h from the operands and holds them
// in a two-entry skid buffer so in_ready never waits on out_ready.
module adder_stage1_pipe
  import adder_stage1_pipe_pkg::*;
#(
  parameter int DATA_W = LEN_DATA,
  parameter int TAG_W  = DEF_TAG_W
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_stage1_pipe_if.slave   bus
);

  typedef struct packed {
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] h;
    logic              c0;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  logic              c0;
  logic [DATA_W-1:0] g_w;
  logic [DATA_W-1:0] p_w;
  logic [DATA_W-1:0] h_w;
  entry_t            entry_new;

  assign c0 = fold_carry(bus.in_cin, bus.in_sub);

  for (genvar i = 0; i < DATA_W; i++) begin : g_cell
    adder_stage1_pipe_gp_bit_cell #(
      .CARRY_FOLD (i == 0)
    ) u_cell (
      .a   (bus.in_a[i]),
      .b   (bus.in_b[i]),
      .sub (bus.in_sub),
      .cin (c0),
      .g   (g_w[i]),
      .p   (p_w[i]),
      .h   (h_w[i])
    );
  end

  assign entry_new = '{g: g_w, p: p_w, h: h_w, c0: c0, tag: bus.in_tag};

  entry_t main_q, skid_q;
  logic   main_valid_q, skid_valid_q;
  logic   main_valid_d, skid_valid_d;
  logic   main_ld, skid_ld, main_from_skid;
  logic   in_ready, accept, xfer;

  // Ready comes straight from a flop, so out_ready has no path to in_ready.
  assign in_ready = ~skid_valid_q;
  assign accept   = bus.in_valid & in_ready;
  assign xfer     = main_valid_q & bus.out_ready;

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    main_valid_d   = main_valid_q;
    skid_valid_d   = skid_valid_q;
    if (xfer) begin
      if (skid_valid_q) begin
        main_ld        = 1'b1;
        main_from_skid = 1'b1;
        skid_valid_d   = 1'b0;
      end else if (accept) begin
        main_ld = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_ld      = 1'b1;
        skid_valid_d = 1'b1;
      end else begin
        main_ld      = 1'b1;
        main_valid_d = 1'b1;
      end
    end
  end

  // NOTE: the data registers are reset too, so the outputs read 0 after reset, not stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      // NOTE: non-blocking here so the skid->main move reads skid_q from before this edge.
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      if (main_ld) main_q <= main_from_skid ? skid_q : entry_new;
      if (skid_ld) skid_q <= entry_new;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = main_valid_q;
  assign bus.generate_out  = main_q.g;
  assign bus.propogate_out = main_q.p;
  assign bus.halfsum_out   = main_q.h;
  assign bus.cin_out       = main_q.c0;
  assign bus.tag_out       = main_q.tag;

endmodule

// File: tb/tb_adder_stage1_pipe.sv
// Directed and random-stall checks of adder_stage1_pipe against a small g/p/h model.
module tb_adder_stage1_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  adder_stage1_pipe_if #(.DATA_W(32), .TAG_W(4)) bus ();

  adder_stage1_pipe #(.DATA_W(32), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] h;
    logic        c0;
    logic [3:0]  tag;
  } exp_t;

  function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic cin, input logic [3:0] tag);
    exp_t        r;
    logic [31:0] bb;
    bb     = sub ? ~b : b;
    r.c0   = cin ^ sub;
    r.h    = a ^ bb;
    r.p    = r.h;
    r.g    = a & bb;
    r.g[0] = r.g[0] | (r.h[0] & r.c0);
    r.tag  = tag;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_entry(input string name, input exp_t e);
    check({name, ".g"},   bus.generate_out,  e.g);
    check({name, ".p"},   bus.propogate_out, e.p);
    check({name, ".h"},   bus.halfsum_out,   e.h);
    check({name, ".cin"}, bus.cin_out,       e.c0);
    check({name, ".tag"}, bus.tag_out,       e.tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic cin, input logic [3:0] tag);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_cin   = cin;
    bus.in_tag   = tag;
  endtask

  task automatic check_zero(input string name);
    check({name, ".out_valid"}, bus.out_valid, 1'b0);
    check({name, ".in_ready"},  bus.in_ready,  1'b1);
    check_entry(name, '0);
  endtask

  exp_t q[$];
  exp_t e;

  initial begin
    int          accepted;
    int          cyc;
    logic        iv, ro, can_acc;
    logic [31:0] ra, rb;
    logic        rs, rc;
    logic [3:0]  rt;

    drive(0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // Plain add
    drive(1, 32'h0000_00FF, 32'h0000_0001, 0, 0, 4'd3);
    @(negedge clk);
    check("add.out_valid", bus.out_valid,     1'b1);
    check("add.g",         bus.generate_out,  32'h0000_0001);
    check("add.p",         bus.propogate_out, 32'h0000_00FE);
    check("add.h",         bus.halfsum_out,   32'h0000_00FE);
    check("add.cin",       bus.cin_out,       1'b0);
    check("add.tag",       bus.tag_out,       4'd3);
    drive(0, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("add.drained", bus.out_valid, 1'b0);

    // Subtract: borrow fold sets g[0]
    drive(1, 32'h0000_0005, 32'h0000_0003, 1, 0, 4'd5);
    @(negedge clk);
    check("sub.g",   bus.generate_out,  32'h0000_0005);
    check("sub.p",   bus.propogate_out, 32'hFFFF_FFF9);
    check("sub.h",   bus.halfsum_out,   32'hFFFF_FFF9);
    check("sub.cin", bus.cin_out,       1'b1);
    check("sub.tag", bus.tag_out,       4'd5);
    drive(1, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 4'd6);
    @(negedge clk);
    check("addc.g",   bus.generate_out, 32'h0000_0001);
    check("addc.h",   bus.halfsum_out,  32'hFFFF_FFFF);
    check("addc.cin", bus.cin_out,      1'b1);
    check("addc.tag", bus.tag_out,      4'd6);
    drive(1, 32'h0000_0005, 32'h0000_0003, 1, 1, 4'd7);
    @(negedge clk);
    check("subb.g",   bus.generate_out, 32'h0000_0004);
    check("subb.cin", bus.cin_out,      1'b0);
    check("subb.tag", bus.tag_out,      4'd7);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("subb.drained", bus.out_valid, 1'b0);

    // Backpressure into the skid register
    bus.out_ready = 1'b0;
    drive(1, 32'h1, 32'h0, 0, 0, 4'd1);
    @(negedge clk);
    check("bp.ready1", bus.in_ready, 1'b1);
    drive(1, 32'h2, 32'h0, 0, 0, 4'd2);
    @(negedge clk);
    check("bp.ready2", bus.in_ready, 1'b0);
    drive(1, 32'h3, 32'h0, 0, 0, 4'd3);
    @(negedge clk);
    check("bp.ready3",  bus.in_ready,  1'b0);
    check("bp.valid",   bus.out_valid, 1'b1);
    check("bp.hold1",   bus.tag_out,   4'd1);
    check("bp.hold1.g", bus.generate_out, 32'h0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp.tag2",    bus.tag_out,  4'd2);
    check("bp.h2",      bus.halfsum_out, 32'h2);
    check("bp.ready4",  bus.in_ready, 1'b1);
    @(negedge clk);
    check("bp.tag3", bus.tag_out,   4'd3);
    check("bp.h3",   bus.halfsum_out, 32'h3);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("bp.drained", bus.out_valid, 1'b0);

    // Reset while both entries are stalled
    bus.out_ready = 1'b0;
    drive(1, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 4'd7);
    @(negedge clk);
    drive(1, 32'hCAFE_F00D, 32'h0F0F_0F0F, 1, 0, 4'd8);
    @(negedge clk);
    check("rst.full", bus.in_ready, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("rst.mid");
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst.nostale", bus.out_valid, 1'b0);
    end

    // Full throughput, latency 1
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        check("tp.valid", bus.out_valid, 1'b1);
        check("tp.ready", bus.in_ready,  1'b1);
        check_entry("tp", e);
      end
      if (i < 16) begin
        ra = 32'h1111_1111 * i;
        rb = 32'h0F0F_00FF ^ (32'(i) << 3);
        rs = i[0];
        rc = i[1];
        rt = i[3:0];
        e  = ref_op(ra, rb, rs, rc, rt);
        drive(1, ra, rb, rs, rc, rt);
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      @(negedge clk);
    end
    check("tp.drained", bus.out_valid, 1'b0);

    // Random valid/ready against the scoreboard
    accepted = 0;
    cyc      = 0;
    while ((accepted < 10000 || q.size() != 0) && cyc < 60000) begin
      check("rnd.out_valid", bus.out_valid, q.size() > 0);
      check("rnd.in_ready",  bus.in_ready,  q.size() < 2);
      if (q.size() > 0) check_entry("rnd", q[0]);
      ro      = ($urandom_range(0, 3) != 0);
      iv      = (accepted < 10000) && ($urandom_range(0, 3) != 0);
      ra      = $urandom;
      rb      = $urandom;
      rs      = 1'($urandom_range(0, 1));
      rc      = 1'($urandom_range(0, 1));
      rt      = 4'($urandom_range(0, 15));
      can_acc = (q.size() < 2);
      bus.out_ready = ro;
      drive(iv, ra, rb, rs, rc, rt);
      if (ro && q.size() > 0) void'(q.pop_front());
      if (iv && can_acc) begin
        q.push_back(ref_op(ra, rb, rs, rc, rt));
        accepted++;
      end
      @(negedge clk);
      cyc++;
    end
    check("rnd.accepted", 64'(accepted), 64'd10000);
    check("rnd.empty",    64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_stage1_pipe.md
Name: adder_stage1_pipe

Overview:
Operand-capture and bitwise generate/propagate front end of the pipelined prefix adder. It accepts A/B operands, a subtract control and a carry-in under a valid/ready handshake. It forms per-bit generate, propagate and half-sum vectors, with the carry-in folded into bit 0, and registers them. Its outputs feed adder_stage2 directly (generate_in/propogate_in) and pass the half-sum forward to the final sum stage.

Parameters:
DATA_W, `LEN_DATA (32), operand and vector width; must be even and >= 2
TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation offered
in_ready  output  1  block can accept an operation this cycle
in_a  input  DATA_W  operand A
in_b  input  DATA_W  operand B
in_sub  input  1  1 = A - B (B inverted)
in_cin  input  1  carry-in (add) / borrow-in (sub)
in_tag  input  TAG_W  opaque tag
out_valid  output  1  registered result present
out_ready  input  1  downstream accepts this cycle
generate_out  output  DATA_W  per-bit generate, carry folded into bit 0
propogate_out  output  DATA_W  per-bit propagate
halfsum_out  output  DATA_W  A ^ B' for the final sum stage
cin_out  output  1  effective carry into bit 0
tag_out  output  TAG_W  tag of the presented result

Behaviour:
- Arithmetic, computed combinationally from the inputs on the accepting cycle:
  - b' = in_sub ? ~in_b : in_b
  - c0 = in_cin ^ in_sub. Sub with in_cin=0 gives A-B; sub with in_cin=1 gives A-B-1.
  - h[i] = a[i]^b'[i]; p[i] = h[i]; g[i] = a[i]&b'[i] for i >= 1
  - g[0] = (a[0]&b'[0]) | (h[0]&c0); p[0] = h[0]
  - All vectors are DATA_W wide; no carry-out is produced here.
- Storage is a 2-entry skid buffer: a main output register plus one skid register, each holding {g, p, h, c0, tag, valid}.
- Accept occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- in_ready is registered and equals !skid_valid. It never depends combinationally on out_ready.
- Accept with main empty, or main transferring the same cycle -> the entry loads main.
- Accept while main is full and not transferring -> the entry loads skid; in_ready goes 0 next cycle.
- Transfer while skid is full -> skid moves to main the same edge; skid clears; in_ready goes 1 next cycle.
- Simultaneous accept and transfer with skid full cannot occur, because in_ready=0.
- Latency: accept at edge N -> out_valid=1 after edge N, data stable until transferred. Full throughput is one op per cycle when out_ready=1.
- Outputs hold their values while out_valid & !out_ready. No data changes under a stalled valid.
- Order is strict FIFO; the tag stays bound to its data.
- Reset (async assert, any cycle including mid-stall): main and skid valid = 0; all data registers = 0; out_valid=0; generate_out, propogate_out, halfsum_out = 0; cin_out=0; tag_out=0; in_ready=1 from the first post-reset edge. In-flight ops are discarded.
- Deassertion of rst is synchronised externally; the block does not re-synchronise it.
- No X propagation: a data register loads only on its enable.

Decomposition:
- Shared `LEN_DATA stays in main.def.v.
- Add a localparam package header adder_pkg.def.v holding DATA_W-derived constants and the entry field layout: G, P, H, C0 and TAG offsets and ENTRY_W.
- Natural sub-module: gp_bit_cell, the per-bit generate/propagate/half-sum combinational cell, instantiated DATA_W times, with bit 0 using its carry-fold variant.
- Skid control stays inline.

Test Plan:
- Reset mid-stall: fill both entries with out_ready=0, assert rst -> out_valid=0, in_ready=1, all outputs 0; no stale op appears after release.
- Add: A=0x0000_00FF, B=0x0000_0001, sub=0, cin=0, tag=3 -> next cycle g=0x0000_0001, p=h=0x0000_00FE, cin_out=0, tag_out=3.
- Sub with carry fold: A=0x0000_0005, B=0x0000_0003, sub=1, cin=0 -> b'=0xFFFF_FFFC, cin_out=1, h=0xFFFF_FFF9, g=0x0000_0005 (bit0 = h0&c0 = 1).
- Backpressure skid: stream tags 1,2,3 with out_ready=0 -> tags 1 and 2 accepted, in_ready=0 on the third; raise out_ready -> tags 1,2,3 emerge in order, none lost or duplicated.
- Full throughput: 16 back-to-back ops with out_ready=1 -> in_ready stays 1, one result per cycle, latency 1.
- Random stall: random in_valid/out_ready over 10k ops against a reference model -> every result bit-exact and in order; in_ready never asserted while the skid register is full.
